// File: rtl/histogram_readout.sv
// Streams every histogram bin as (bin, count) beats once accumulation is done.
// Tracks the peak bin and the running total, and freezes upstream writes while it scans.
module histogram_readout #(
    parameter int NUM_BINS = 128,
    parameter int SIZE     = 7,
    parameter int RD_LAT   = 2,
    localparam int BIN_W   = $clog2(NUM_BINS)
) (
    input  logic                  clk_50,
    input  logic                  RST,
    input  logic                  start,
    output logic                  hist_hold,
    output logic [BIN_W-1:0]      rd_addr,
    input  logic [SIZE-1:0]       rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic [SIZE-1:0]       out_count,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      peak_bin,
    output logic [SIZE-1:0]       peak_count,
    output logic [SIZE+BIN_W-1:0] total
);

    localparam int TOT_W = SIZE + BIN_W;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
    localparam logic [BIN_W-1:0] ONE_BIN  = BIN_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

    state_t             r_state;
    logic [BIN_W-1:0]   r_ptr;
    logic [BIN_W-1:0]   r_rd_addr;
    logic [RD_LAT-1:0]  r_tag_vld;
    logic [BIN_W-1:0]   r_tag_bin [RD_LAT];
    logic [BIN_W-1:0]   r_fifo_bin [4];
    logic [SIZE-1:0]    r_fifo_cnt [4];
    logic [1:0]         r_wptr;
    logic [1:0]         r_rptr;
    logic [2:0]         r_fcnt;
    logic               r_hold;
    logic               r_done;
    logic [BIN_W-1:0]   r_peak_bin;
    logic [SIZE-1:0]    r_peak_count;
    logic [TOT_W-1:0]   r_total;

    logic [2:0]         w_in_flight;
    logic [BIN_W-1:0]   w_issue_bin;
    logic               w_issue;
    logic               w_wr;
    logic [BIN_W-1:0]   w_wr_bin;
    logic               w_out_valid;
    logic               w_pop;
    logic [BIN_W-1:0]   w_head_bin;
    logic               w_head_last;

    // Reads in flight plus buffered beats never exceed the 4 FIFO slots.
    always_comb begin
        w_in_flight = 3'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_in_flight = w_in_flight + {2'b00, r_tag_vld[i]};
        end
    end

    assign w_issue_bin = (r_state == S_IDLE) ? '0 : r_ptr;
    assign w_issue     = (r_state == S_IDLE) ? start :
                         ((r_state == S_SCAN) && (({1'b0, r_fcnt} + {1'b0, w_in_flight}) < 4'd4));
    assign w_wr        = r_tag_vld[RD_LAT-1];
    assign w_wr_bin    = r_tag_bin[RD_LAT-1];
    assign w_out_valid = (r_fcnt != 3'd0);
    assign w_pop       = w_out_valid && out_ready;
    assign w_head_bin  = r_fifo_bin[r_rptr];
    assign w_head_last = (w_head_bin == LAST_BIN);

    always_ff @(posedge clk_50) begin
        if (w_wr) begin
            r_fifo_bin[r_wptr] <= w_wr_bin;
            r_fifo_cnt[r_wptr] <= rd_data;
        end
    end

    always_ff @(posedge clk_50) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_rd_addr    <= '0;
            r_tag_vld    <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_bin[i] <= '0;
            end
            r_wptr       <= 2'd0;
            r_rptr       <= 2'd0;
            r_fcnt       <= 3'd0;
            r_hold       <= 1'b0;
            r_done       <= 1'b0;
            r_peak_bin   <= '0;
            r_peak_count <= '0;
            r_total      <= '0;
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_bin[0] <= w_issue_bin;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_bin[i] <= r_tag_bin[i-1];
            end
            if (w_issue) begin
                r_rd_addr <= w_issue_bin;
                r_ptr     <= w_issue_bin + ONE_BIN;
            end
            // Strict compare keeps the lowest bin on ties.
            if (w_wr) begin
                r_wptr  <= r_wptr + 2'd1;
                r_total <= r_total + {{BIN_W{1'b0}}, rd_data};
                if (rd_data > r_peak_count) begin
                    r_peak_count <= rd_data;
                    r_peak_bin   <= w_wr_bin;
                end
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            r_fcnt <= r_fcnt + {2'b00, w_wr} - {2'b00, w_pop};
            r_done <= 1'b0;
            if (r_done) begin
                r_hold <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= (w_issue_bin == LAST_BIN) ? S_DRAIN : S_SCAN;
                        r_hold       <= 1'b1;
                        r_peak_bin   <= '0;
                        r_peak_count <= '0;
                        r_total      <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_issue && (w_issue_bin == LAST_BIN)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_head_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    a_no_fifo_overflow: assert property (@(posedge clk_50) disable iff (RST)
        !(w_wr && !w_pop && (r_fcnt == 3'd4)));

    assign hist_hold  = r_hold;
    assign rd_addr    = r_rd_addr;
    assign out_valid  = w_out_valid;
    assign out_bin    = w_out_valid ? w_head_bin : '0;
    assign out_count  = w_out_valid ? r_fifo_cnt[r_rptr] : '0;
    assign out_last   = w_out_valid && w_head_last;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign peak_bin   = r_peak_bin;
    assign peak_count = r_peak_count;
    assign total      = r_total;

endmodule

// File: tb/tb_histogram_readout.sv
// Bench for histogram_readout: RAM model, reference scan results and beat ordering,
// randomized contents and downstream backpressure.
module tb_histogram_readout;

    localparam int NB = 128;
    localparam int SZ = 7;
    localparam int BW = 7;

    logic          clk_50 = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          hist_hold, out_valid, out_last, busy, done;
    logic [BW-1:0] rd_addr, out_bin, peak_bin;
    logic [SZ-1:0] rd_data, out_count, peak_count;
    logic [SZ+BW-1:0] total;
    logic [SZ-1:0] mem [NB];

    int errors = 0;
    int checks = 0;

    histogram_readout dut (
        .clk_50(clk_50), .RST(RST), .start(start), .hist_hold(hist_hold),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_bin(out_bin), .out_count(out_count),
        .out_last(out_last), .busy(busy), .done(done), .peak_bin(peak_bin),
        .peak_count(peak_count), .total(total)
    );

    always #10 clk_50 = ~clk_50;

    // Two-cycle RAM: the DUT's rd_addr register plus this output register.
    always @(posedge clk_50) rd_data <= mem[rd_addr];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(output int pb, output int pc, output int tot);
        pb = 0; pc = 0; tot = 0;
        for (int b = 0; b < NB; b++) begin
            tot += int'(mem[b]);
            if (int'(mem[b]) > pc) begin
                pc = int'(mem[b]);
                pb = b;
            end
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
        return 1'($urandom % 2);
    endfunction

    task automatic check_idle_zero(input string name);
        chk({name, "_valid"}, out_valid, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_hold"}, hist_hold, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_rdaddr"}, rd_addr, 0);
        chk({name, "_outbin"}, out_bin, 0);
        chk({name, "_outcnt"}, out_count, 0);
        chk({name, "_last"}, out_last, 0);
        chk({name, "_peakbin"}, peak_bin, 0);
        chk({name, "_peakcnt"}, peak_count, 0);
        chk({name, "_total"}, total, 0);
    endtask

    // mode 0: ready always 1; 1: pattern 1,0,0,1; 2: random ready.
    task automatic run_scan(input string name, input int mode, input int abort_bin, input bit mid_start);
        int nxt = 0;
        int gaps = 0;
        int first = -1;
        int pb, pc, tot;
        bit finished = 1'b0;
        model(pb, pc, tot);
        @(negedge clk_50);
        start = 1'b1;
        out_ready = ready_for(mode, 0);
        for (int cyc = 1; cyc < 2000 && !finished; cyc++) begin
            @(negedge clk_50);
            start = mid_start && (cyc == 60);
            out_ready = ready_for(mode, cyc);
            if (done) begin
                chk({name, "_beats"}, nxt, NB);
                if (mode == 0) begin
                    chk({name, "_done_cyc"}, cyc, 3 + NB);
                    chk({name, "_gaps"}, gaps, 0);
                end
                chk({name, "_busy_at_done"}, busy, 0);
                chk({name, "_hold_at_done"}, hist_hold, 1);
                chk({name, "_peak_bin"}, peak_bin, pb);
                chk({name, "_peak_count"}, peak_count, pc);
                chk({name, "_total"}, total, tot);
                start = 1'b0;
                @(negedge clk_50);
                chk({name, "_hold_after"}, hist_hold, 0);
                chk({name, "_done_pulse"}, done, 0);
                chk({name, "_total_held"}, total, tot);
                $display("scan %s: beats=%0d peak_bin=%0d peak_count=%0d total=%0d", name, nxt, peak_bin, peak_count, total);
                finished = 1'b1;
            end else if (out_valid) begin
                if (first < 0) begin
                    first = cyc;
                    if (mode == 0) chk({name, "_first_cyc"}, cyc, 3);
                end
                if (nxt >= NB) begin
                    chk({name, "_extra_beat"}, nxt, NB - 1);
                end else begin
                    chk({name, "_beat_bin"}, out_bin, nxt);
                    chk({name, "_beat_count"}, out_count, mem[nxt]);
                    chk({name, "_beat_last"}, out_last, (nxt == NB - 1) ? 1 : 0);
                end
                if (abort_bin == nxt) begin
                    RST = 1'b1;
                    @(negedge clk_50);
                    check_idle_zero({name, "_abort"});
                    RST = 1'b0;
                    $display("scan %s: aborted at bin %0d", name, abort_bin);
                    finished = 1'b1;
                end else if (out_ready) begin
                    nxt++;
                end
            end else if (mode == 0 && first >= 0) begin
                gaps++;
            end
        end
        start = 1'b0;
        if (!finished) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic fill_random(input int maxv);
        for (int b = 0; b < NB; b++) mem[b] = SZ'($urandom_range(0, maxv));
    endtask

    initial begin
        for (int b = 0; b < NB; b++) mem[b] = '0;
        repeat (3) @(negedge clk_50);
        check_idle_zero("reset");
        RST = 1'b0;
        @(negedge clk_50);
        check_idle_zero("post_reset");

        mem[5] = 7'd9; mem[100] = 7'd9; mem[3] = 7'd2;
        run_scan("t1_ready", 0, -1, 1'b0);
        run_scan("t3_pattern", 1, -1, 1'b0);

        for (int b = 0; b < NB; b++) mem[b] = 7'd127;
        run_scan("t4_full", 0, -1, 1'b0);

        fill_random(127);
        run_scan("t5_abort", 0, 40, 1'b0);
        run_scan("t5_clean", 0, -1, 1'b0);

        fill_random(15);
        run_scan("t6_midstart", 0, -1, 1'b1);

        @(negedge clk_50);
        start = 1'b1; RST = 1'b1;
        @(negedge clk_50);
        start = 1'b0; RST = 1'b0;
        chk("t6_rst_start_busy", busy, 0);
        chk("t6_rst_start_hold", hist_hold, 0);
        @(negedge clk_50);
        chk("t6_rst_start_busy2", busy, 0);
        chk("t6_rst_start_valid", out_valid, 0);

        for (int r = 0; r < 3; r++) begin
            fill_random((r == 0) ? 3 : 127);
            run_scan($sformatf("rand%0d", r), 2, -1, 1'b0);
        end
        run_scan("rand_pattern", 1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
